multi_edge_pulser: RTL and testbench

MULTI_EDGE_PULSER -- requirements
Module: multi_edge_pulser

---
 rtl/multi_edge_pulser.sv | 116 +++++++++++
 tb/tb_multi_edge_pulser.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/multi_edge_pulser.sv
// multi_edge_pulser
//   N independent channels. Each raw input is synchronised, debounced, and
//   turned into one-cycle pulses on accepted edges. The edges that pulse are
//   chosen per channel by mode. An optional auto-repeat emits further pulses
//   while a channel is held high.
//
// Ports
//   clk    : clock, all state updates on the rising edge
//   rst    : synchronous, active-high reset
//   in     : [N-1:0] asynchronous raw inputs, bit i is channel i
//   mode   : [2N-1:0] per-channel mode, bits [2i+1:2i]
//            00 off, 01 rise, 10 fall, 11 both
//   pulse  : [N-1:0] registered one-cycle pulse per accepted edge or repeat
//   level  : [N-1:0] debounced level
module multi_edge_pulser #(
    parameter int N             = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int DB_CYCLES     = 4,
    parameter int REPEAT_DELAY  = 0,
    parameter int REPEAT_PERIOD = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   in,
    input  logic [2*N-1:0] mode,
    output logic [N-1:0]   pulse,
    output logic [N-1:0]   level
);

    localparam int DB_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int HOLD_W = (REPEAT_DELAY > 0) ? $clog2(REPEAT_DELAY + 1) : 1;
    localparam int PER_W  = (REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD) : 1;

    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(REPEAT_DELAY);
    localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [PER_W-1:0]  PER_LAST = PER_W'(REPEAT_PERIOD - 1);
    localparam bit                REP_EN   = (REPEAT_DELAY > 0);

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [DB_W-1:0]        cnt_q;
        logic                   level_q;
        logic                   pulse_q;
        logic                   pulse_d;
        logic [HOLD_W-1:0]      hold_q;
        logic [PER_W-1:0]       per_q;

        logic s;
        logic diff;
        logic accept;
        logic rise_acc;
        logic fall_acc;
        logic hold_done;
        logic rep_evt;

        assign s         = sync_q[SYNC_STAGES-1];
        assign diff      = s ^ level_q;
        assign accept    = diff && (cnt_q == DB_LAST);
        assign rise_acc  = accept && s;
        assign fall_acc  = accept && !s;
        assign hold_done = (hold_q == HOLD_MAX);

        // First repeat fires as the hold counter reaches REPEAT_DELAY; after
        // that the period counter takes over. Nothing repeats on the edge the
        // level is dropping.
        assign rep_evt = REP_EN && level_q && !fall_acc &&
                         (hold_done ? (per_q == PER_LAST) : (hold_q == HOLD_PRE));

        // A repeat directly behind another pulse is dropped so the output
        // always returns low between pulses.
        assign pulse_d = (rise_acc && mode[2*i])   ||
                         (fall_acc && mode[2*i+1]) ||
                         (rep_evt  && mode[2*i] && !pulse_q);

        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q  <= '0;
                cnt_q   <= '0;
                level_q <= 1'b0;
                pulse_q <= 1'b0;
                hold_q  <= '0;
                per_q   <= '0;
            end else begin
                sync_q  <= {sync_q[SYNC_STAGES-2:0], in[i]};
                pulse_q <= pulse_d;

                if (!diff) begin
                    cnt_q <= '0;
                end else if (accept) begin
                    cnt_q   <= '0;
                    level_q <= s;
                end else if (cnt_q != DB_LAST) begin
                    cnt_q <= cnt_q + DB_W'(1);
                end

                // Hold/period timers run regardless of mode so that toggling
                // mode bit0 while held keeps the original repeat schedule.
                if (rise_acc || !level_q) begin
                    hold_q <= '0;
                    per_q  <= '0;
                end else if (!hold_done) begin
                    hold_q <= hold_q + HOLD_W'(1);
                end else if (per_q == PER_LAST) begin
                    per_q <= '0;
                end else begin
                    per_q <= per_q + PER_W'(1);
                end
            end
        end

        assign pulse[i] = pulse_q;
        assign level[i] = level_q;
    end

endmodule

// File: tb/tb_multi_edge_pulser.sv
module tb_multi_edge_pulser;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   in0, in1;
    logic [2*N-1:0] mode0, mode1;
    logic [N-1:0]   pulse0, level0, pulse1, level1;

    always #5 clk = ~clk;

    multi_edge_pulser #(.N(N)) dut0 (
        .clk   (clk),
        .rst   (rst),
        .in    (in0),
        .mode  (mode0),
        .pulse (pulse0),
        .level (level0)
    );

    multi_edge_pulser #(.N(N), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .in    (in1),
        .mode  (mode1),
        .pulse (pulse1),
        .level (level1)
    );

    typedef struct {
        bit         sel;
        logic       rst;
        logic [3:0] in;
        logic [7:0] mode;
        logic [3:0] ep;
        logic [3:0] el;
        int         tag;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic void add(bit sel, logic r, logic [3:0] i, logic [7:0] m,
                                logic [3:0] p, logic [3:0] l, int tag);
        vec_t v;
        v.sel = sel; v.rst = r; v.in = i; v.mode = m;
        v.ep = p; v.el = l; v.tag = tag;
        tbl.push_back(v);
    endfunction

    function automatic void add_reset(int tag);
        for (int k = 0; k < 2; k++)
            add(1'b0, 1'b1, 4'b0000, 8'h55, 4'b0000, 4'b0000, tag);
    endfunction

    // slow square wave on channel 0: 1 for 10 cycles, 0 for 10, for 40 cycles
    function automatic bit d_in(int k);
        return (k >= 1 && k <= 40 && ((k - 1) / 10) % 2 == 0);
    endfunction

    task automatic apply(input vec_t v);
        vec_t e;
        logic [3:0] p, l;
        rst = v.rst;
        if (v.sel) begin
            in1 = v.in; mode1 = v.mode;
        end else begin
            in0 = v.in; mode0 = v.mode;
        end
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        p = e.sel ? pulse1 : pulse0;
        l = e.sel ? level1 : level0;
        n_vec++;
        if (p !== e.ep || l !== e.el) begin
            n_err++;
            $display("FAIL seq%0d vec%0d: pulse=%b level=%b, expected pulse=%b level=%b",
                     e.tag, n_vec, p, l, e.ep, e.el);
        end
    endtask

    function automatic vec_t mk(logic r, logic [3:0] i, logic [7:0] m,
                                logic [3:0] p, logic [3:0] l, int tag);
        vec_t v;
        v.sel = 1'b1; v.rst = r; v.in = i; v.mode = m;
        v.ep = p; v.el = l; v.tag = tag;
        return v;
    endfunction

    initial begin
        rst = 1'b1; in0 = '0; in1 = '0; mode0 = 8'h55; mode1 = 8'h55;

        // reset state
        add_reset(0);
        // single rise on ch0, then release (fall not enabled)
        for (int e = 1; e <= 12; e++)
            add(0, 0, 4'b0001, 8'h55, (e == 6) ? 4'b0001 : 4'b0000,
                (e >= 6) ? 4'b0001 : 4'b0000, 1);
        for (int e = 1; e <= 8; e++)
            add(0, 0, 4'b0000, 8'h55, 4'b0000, (e >= 6) ? 4'b0000 : 4'b0001, 2);
        // 3-cycle glitch on ch1 is rejected
        add_reset(3);
        for (int e = 1; e <= 12; e++)
            add(0, 0, (e <= 3) ? 4'b0010 : 4'b0000, 8'h55, 4'b0000, 4'b0000, 3);
        // both-edge mode on ch2
        add_reset(4);
        for (int e = 1; e <= 30; e++)
            add(0, 0, (e <= 20) ? 4'b0100 : 4'b0000, 8'h75,
                (e == 6 || e == 26) ? 4'b0100 : 4'b0000,
                (e >= 6 && e < 26) ? 4'b0100 : 4'b0000, 4);
        // mode 00 on ch0: level tracks, no pulses
        add_reset(5);
        for (int e = 1; e <= 45; e++)
            add(0, 0, {3'b000, d_in(e)}, 8'h54, 4'b0000,
                {3'b000, (e > 5) ? d_in(e - 5) : 1'b0}, 5);
        // reset during debounce, input held high
        add_reset(6);
        for (int e = 1; e <= 14; e++)
            add(0, (e == 4 || e == 5), 4'b0001, 8'h55,
                (e == 11) ? 4'b0001 : 4'b0000, (e >= 11) ? 4'b0001 : 4'b0000, 6);
        // mode only matters at the acceptance edge; then fall-only mode
        add_reset(7);
        for (int e = 1; e <= 10; e++)
            add(0, 0, 4'b0010, (e == 6) ? 8'h55 : 8'h51,
                (e == 6) ? 4'b0010 : 4'b0000, (e >= 6) ? 4'b0010 : 4'b0000, 7);
        for (int e = 1; e <= 8; e++)
            add(0, 0, 4'b0000, 8'h59, (e == 6) ? 4'b0010 : 4'b0000,
                (e >= 6) ? 4'b0000 : 4'b0010, 8);
        // all channels together, both edges
        add_reset(9);
        for (int e = 1; e <= 20; e++)
            add(0, 0, (e <= 10) ? 4'b1111 : 4'b0000, 8'hFF,
                (e == 6 || e == 16) ? 4'b1111 : 4'b0000,
                (e >= 6 && e < 16) ? 4'b1111 : 4'b0000, 9);

        for (int k = 0; k < tbl.size(); k++)
            apply(tbl[k]);

        // auto-repeat: delay 10, period 5, ch3 held 40 cycles
        for (int k = 0; k < 2; k++) apply(mk(1, 4'b0000, 8'h55, 4'b0000, 4'b0000, 10));
        for (int e = 1; e <= 50; e++)
            apply(mk(0, (e <= 40) ? 4'b1000 : 4'b0000, 8'h55,
                     (e == 6 || (e >= 16 && e <= 41 && (e - 16) % 5 == 0)) ? 4'b1000 : 4'b0000,
                     (e >= 6 && e < 46) ? 4'b1000 : 4'b0000, 10));

        // bit0 cleared around edge 21 suppresses that repeat only
        for (int k = 0; k < 2; k++) apply(mk(1, 4'b0000, 8'h55, 4'b0000, 4'b0000, 11));
        for (int e = 1; e <= 40; e++)
            apply(mk(0, (e <= 30) ? 4'b1000 : 4'b0000,
                     (e >= 19 && e <= 23) ? 8'h15 : 8'h55,
                     (e == 6 || e == 16 || e == 26 || e == 31) ? 4'b1000 : 4'b0000,
                     (e >= 6 && e < 36) ? 4'b1000 : 4'b0000, 11));

        // reset mid-repeat, input stays high
        for (int k = 0; k < 2; k++) apply(mk(1, 4'b0000, 8'h55, 4'b0000, 4'b0000, 12));
        for (int e = 1; e <= 28; e++)
            apply(mk((e == 18), 4'b1000, 8'h55,
                     (e == 6 || e == 16 || e == 24) ? 4'b1000 : 4'b0000,
                     ((e >= 6 && e < 18) || e >= 24) ? 4'b1000 : 4'b0000, 12));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
